// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST run sequencer: FSM state encoding,
// default session timing and the run-counter width.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        WAIT   = 3'd2,
        GAP    = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam int BIST_ARM_CYCLES     = 2;
    localparam int BIST_GAP_CYCLES     = 4;
    // Comfortably above 2000 patterns x 58 cycles per BIST session.
    localparam int BIST_TIMEOUT_CYCLES = 131072;
    localparam int BIST_RUN_W          = 8;

endpackage

// File: rtl/bist_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Holds at all-ones instead of wrapping.
module bist_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bist_run_sequencer.sv
// Host-side BIST session sequencer: arms the chip BIST, waits for bistdone under a
// watchdog and tallies results. Define BIST_FAIL_STOP_EN to stop after the first failing run.
module bist_run_sequencer
    import bist_pkg::*;
#(
    parameter int ARM_CYCLES     = BIST_ARM_CYCLES,
    parameter int GAP_CYCLES     = BIST_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = BIST_TIMEOUT_CYCLES,
    parameter int RUN_W          = BIST_RUN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RUN_W-1:0] run_count,
    output logic             busy,
    output logic             done,
    output logic             all_pass,
    output logic [RUN_W-1:0] pass_cnt,
    output logic [RUN_W-1:0] fail_cnt,
    output logic             timeout_err,
    output logic             bist_rst,
    output logic             bistmode,
    input  logic             bistdone,
    input  logic             bistpass
);

    localparam int PH_MAX = (ARM_CYCLES > GAP_CYCLES) ? ARM_CYCLES : GAP_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

    state_t           state_reg;
    state_t           state_next;
    logic [PH_W-1:0]  phase_reg;
    logic [WD_W-1:0]  wdog_reg;
    logic [RUN_W-1:0] runs_target_reg;
    logic [RUN_W-1:0] runs_done;
    logic             bistdone_reg;

    logic start_acc;
    logic done_edge;
    logic in_wait;
    logic run_pass;
    logic run_fail;
    logic run_end;
    logic wd_expire;
    logic arm_last;
    logic gap_last;
    logic more_runs;
    logic stop_early;

    assign start_acc = (state_reg == IDLE) && start;
    assign done_edge = bistdone && !bistdone_reg;
    assign in_wait   = (state_reg == WAIT);
    // A bistdone edge in the final watchdog cycle still counts as a completed run.
    assign wd_expire = in_wait && !done_edge && (wdog_reg == WD_W'(TIMEOUT_CYCLES - 1));
    assign run_pass  = in_wait && done_edge && bistpass;
    assign run_fail  = (in_wait && done_edge && !bistpass) || wd_expire;
    assign run_end   = (in_wait && done_edge) || wd_expire;
    assign arm_last  = (phase_reg == PH_W'(ARM_CYCLES - 1));
    assign gap_last  = (phase_reg == PH_W'(GAP_CYCLES - 1));
    assign more_runs = (runs_done < runs_target_reg);

`ifdef BIST_FAIL_STOP_EN
    assign stop_early = (fail_cnt != '0);
`else
    assign stop_early = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ARM;
            ARM:     if (arm_last) state_next = WAIT;
            WAIT: begin
                if (done_edge) begin
                    state_next = GAP;
                end else if (wd_expire) begin
                    state_next = FINISH;
                end
            end
            GAP: begin
                if (gap_last) begin
                    state_next = (more_runs && !stop_early) ? ARM : FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from state_next so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            phase_reg       <= '0;
            wdog_reg        <= '0;
            runs_target_reg <= '0;
            bistdone_reg    <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            all_pass        <= 1'b0;
            timeout_err     <= 1'b0;
            bist_rst        <= 1'b0;
            bistmode        <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bistdone_reg <= bistdone;

            if ((state_next != state_reg) || ((state_reg != ARM) && (state_reg != GAP))) begin
                phase_reg <= '0;
            end else begin
                phase_reg <= phase_reg + 1'b1;
            end

            wdog_reg <= in_wait ? (wdog_reg + 1'b1) : '0;

            if (start_acc) begin
                runs_target_reg <= (run_count == '0) ? RUN_W'(1) : run_count;
                timeout_err     <= 1'b0;
                all_pass        <= 1'b0;
            end else begin
                if (wd_expire) begin
                    timeout_err <= 1'b1;
                end
                if ((state_reg == GAP) && (state_next == FINISH)) begin
                    all_pass <= (fail_cnt == '0) && !timeout_err;
                end
            end

            busy     <= (state_next != IDLE);
            done     <= (state_next == FINISH);
            bist_rst <= (state_next == ARM);
            bistmode <= (state_next == ARM) || (state_next == WAIT);
        end
    end

    bist_sat_counter #(.W(RUN_W)) u_pass_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .en    (run_pass),
        .count (pass_cnt)
    );

    bist_sat_counter #(.W(RUN_W)) u_fail_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .en    (run_fail),
        .count (fail_cnt)
    );

    bist_sat_counter #(.W(RUN_W)) u_runs_done (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .en    (run_end),
        .count (runs_done)
    );

endmodule
